// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 32x8 VeriRISC memory between the CPU
// (port A) and the program loader / debug port (port B). Each cycle it grants
// one port with round-robin on ties. A granted port that also asserts lock_x
// holds the memory exclusively for at most MAX_LOCK cycles.
module mem_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              lock_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              lock_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    state_t     state, state_nxt;
    logic       last, last_nxt;          // 0: A was granted last, 1: B
    logic [7:0] lock_cnt, lock_cnt_nxt;
    logic       barred_a, barred_a_nxt;  // A may not re-lock until B is granted
    logic       barred_b, barred_b_nxt;  // B may not re-lock until A is granted
    logic       grant_a, grant_b;        // arbitration result before reset gating

    // Arbitration: round-robin in ARB, owner-only while a lock is held
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state)
            ARB: begin
                if (req_a && req_b) begin
                    grant_a = last;
                    grant_b = ~last;
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
            end
            LOCK_A:  grant_a = req_a;
            LOCK_B:  grant_b = req_b;
            default: ;
        endcase
    end

    // Next state: lock entry, voluntary exit, forced exit at the lock limit
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        lock_cnt_nxt = lock_cnt;
        barred_a_nxt = barred_a;
        barred_b_nxt = barred_b;

        if (grant_a) begin
            last_nxt     = 1'b0;
            barred_b_nxt = 1'b0;
        end
        if (grant_b) begin
            last_nxt     = 1'b1;
            barred_a_nxt = 1'b0;
        end

        unique case (state)
            ARB: begin
                if (grant_a && lock_a && !barred_a) begin
                    state_nxt    = LOCK_A;
                    lock_cnt_nxt = 8'd1;
                end else if (grant_b && lock_b && !barred_b) begin
                    state_nxt    = LOCK_B;
                    lock_cnt_nxt = 8'd1;
                end
            end
            LOCK_A: begin
                if (!lock_a) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_LIMIT) begin
                    // Forced release: A must see B granted before locking again
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    last_nxt     = 1'b0;
                    barred_a_nxt = 1'b1;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end
            LOCK_B: begin
                if (!lock_b) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LOCK_LIMIT) begin
                    state_nxt    = ARB;
                    lock_cnt_nxt = '0;
                    last_nxt     = 1'b1;
                    barred_b_nxt = 1'b1;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = ARB;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB;
            last     <= 1'b1;
            lock_cnt <= '0;
            barred_a <= 1'b0;
            barred_b <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
            barred_a <= barred_a_nxt;
            barred_b <= barred_b_nxt;
        end
    end

    // Grants and memory strobes; reset forces everything inactive at once
    always_comb begin
        gnt_a     = reset & grant_a;
        gnt_b     = reset & grant_b;
        mem_rd    = reset & ((grant_a & ~we_a) | (grant_b & ~we_b));
        mem_wr    = reset & ((grant_a & we_a) | (grant_b & we_b));
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset) begin
            mem_addr  = grant_b ? addr_b  : addr_a;
            mem_wdata = grant_b ? wdata_b : wdata_a;
        end
    end

    // Read-return flags, one cycle after a read grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= grant_a & ~we_a;
            rvalid_b <= grant_b & ~we_b;
        end
    end

    assign rdata_a = mem_rdata;
    assign rdata_b = mem_rdata;

endmodule
